// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp sequencer.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    RAMP  = 2'd2,
    FAULT = 2'd3
  } pwm_ramp_state_t;

  localparam int PWM_RESOLUTION_DEFAULT = 8;
  localparam int PWM_STEP_W_DEFAULT     = 4;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; o_period_tick is high in the last cycle of each period.
// Shares reset with the PWM generator counter so every channel stays phase-aligned.
module pwm_period_timer #(
  parameter int RESOLUTION = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_period_tick
);

  logic [RESOLUTION-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_period_tick = &r_count;

endmodule

// File: rtl/pwm_ramp_controller.sv
// Slews the PWM duty toward a commanded target once per period; cmd_ready = enable (and not faulted).
// Duty changes 1..2^RESOLUTION cycles after a command; PWM_RAMP_FAULT_EN adds the fault ports and FAULT state.
module pwm_ramp_controller
  import pwm_pkg::*;
#(
  parameter int RESOLUTION = PWM_RESOLUTION_DEFAULT,
  parameter int STEP_W     = PWM_STEP_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [RESOLUTION-1:0] cmd_duty,
  input  logic [STEP_W-1:0]     cmd_step,
  output logic [RESOLUTION-1:0] duty,
  output logic                  period_tick,
  output logic                  busy,
  output logic                  at_target
`ifdef PWM_RAMP_FAULT_EN
  ,
  input  logic                  fault_in,
  input  logic                  fault_clr,
  output logic                  fault
`endif
);

  pwm_ramp_state_t       r_state, w_state_nxt;
  logic [RESOLUTION-1:0] r_duty, r_target, w_duty_nxt, w_target_nxt, w_slew;
  logic [STEP_W-1:0]     r_step, w_step_nxt;
  logic [RESOLUTION:0]   w_step_ext, w_sum, w_diff, w_tgt_ext;
  logic                  w_tick, w_xfer;

  pwm_period_timer #(
    .RESOLUTION (RESOLUTION)
  ) u_timer (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_period_tick (w_tick)
  );

  // One extra bit keeps the sum from wrapping and exposes the borrow of the difference.
  assign w_step_ext = {{(RESOLUTION+1-STEP_W){1'b0}}, r_step};
  assign w_tgt_ext  = {1'b0, r_target};
  assign w_sum      = {1'b0, r_duty} + w_step_ext;
  assign w_diff     = {1'b0, r_duty} - w_step_ext;

  always_comb begin
    w_slew = r_duty;
    if (r_step == '0) begin
      w_slew = r_target;
    end else if (r_duty < r_target) begin
      w_slew = (w_sum >= w_tgt_ext) ? r_target : w_sum[RESOLUTION-1:0];
    end else if (r_duty > r_target) begin
      w_slew = (w_diff[RESOLUTION] || (w_diff[RESOLUTION-1:0] <= r_target)) ?
               r_target : w_diff[RESOLUTION-1:0];
    end
  end

`ifdef PWM_RAMP_FAULT_EN
  assign cmd_ready = enable && (r_state != FAULT);
  assign fault     = (r_state == FAULT);
`else
  assign cmd_ready = enable;
`endif
  assign w_xfer = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_target <= '0;
      r_step   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_target <= w_target_nxt;
      r_step   <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;

    // A tick always uses the target/step held before this edge.
    if (w_tick) begin
      if (!enable || (r_state == IDLE)) begin
        w_duty_nxt = '0;
      end else if (r_state == RAMP) begin
        w_duty_nxt = w_slew;
      end
    end

    case (r_state)
      IDLE:    if (enable) w_state_nxt = HOLD;
      RAMP:    if (w_tick && (w_slew == r_target)) w_state_nxt = HOLD;
      default: ;
    endcase

    if (w_xfer) begin
      w_target_nxt = cmd_duty;
      w_step_nxt   = cmd_step;
      w_state_nxt  = (cmd_duty != w_duty_nxt) ? RAMP : HOLD;
    end

    if (!enable) begin
      w_state_nxt  = IDLE;
      w_target_nxt = '0;
    end

`ifdef PWM_RAMP_FAULT_EN
    if (r_state == FAULT) begin
      w_state_nxt  = (fault_clr && !fault_in) ? IDLE : FAULT;
      w_duty_nxt   = '0;
      w_target_nxt = '0;
    end
    if (fault_in) begin
      w_state_nxt  = FAULT;
      w_duty_nxt   = '0;
      w_target_nxt = '0;
    end
`endif
  end

  assign duty        = r_duty;
  assign period_tick = w_tick;
  assign busy        = (r_state == RAMP);
  assign at_target   = (r_state == HOLD);

endmodule
